// File: rtl/nibble_serial_cla_sub.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_cla_sub
// Description : Multi-cycle WIDTH-bit subtractor computing d = a - b - bin.
//               A single 4-bit carry-lookahead slice evaluates a + ~b + ~bin
//               one nibble per clock, LSB nibble first. The inter-nibble
//               carry (inverted borrow) is held in a register.
//               start/ready/done handshake; back-to-back starts are accepted
//               in the DONE cycle with no bubble.
// Ports       : clk   - rising-edge clock
//               rst   - asynchronous active-high reset
//               start - request, sampled only while ready=1
//               a, b  - minuend / subtrahend (WIDTH bits), captured on accept
//               bin   - borrow-in, captured on accept
//               ready - high in IDLE and DONE
//               done  - one-cycle pulse, d/bout/ovf valid
//               d     - difference, held until the next accepted start
//               bout  - borrow-out (1 = unsigned a < b + bin)
//               ovf   - two's-complement overflow of a - b - bin
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_cla_sub #(
    parameter int WIDTH = 16   // multiple of 4, >= 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int c_nibbles = WIDTH / 4;
    localparam int c_idx_w   = (c_nibbles > 1) ? $clog2(c_nibbles) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nibbles - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_ready;
    logic                 w_done;
    logic                 w_accept;
    logic                 w_last;

    // Captured operands shift right one nibble per RUN cycle so the slice
    // always reads bits [3:0]; no wide operand multiplexer is needed.
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_carry;
    logic [c_idx_w-1:0]   r_idx;
    logic [WIDTH-1:0]     r_d;
    logic                 r_bout;
    logic                 r_ovf;

    logic [3:0]           w_an;
    logic [3:0]           w_bn;
    logic [3:0]           w_g;
    logic [3:0]           w_p;
    logic [4:0]           w_c;
    logic [3:0]           w_sum;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_last = (r_idx == c_last_idx);

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_ready = 1'b1;
                w_done  = 1'b1;
                w_state_next = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_accept = w_ready & start;

    // ------------------------------------------------------------------
    // 4-bit carry-lookahead slice on a + ~b + carry
    // ------------------------------------------------------------------
    assign w_an = r_a[3:0];
    assign w_bn = ~r_b[3:0];
    assign w_g  = w_an & w_bn;
    assign w_p  = w_an ^ w_bn;

    always_comb begin
        w_c    = '0;
        w_c[0] = r_carry;
        w_c[1] = w_g[0] | (w_p[0] & r_carry);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
    end

    assign w_sum = w_p ^ w_c[3:0];

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= ~bin;      // borrow-in becomes an inverted carry-in
            r_idx   <= '0;
            r_d     <= '0;
        end else if (r_state == ST_RUN) begin
            r_a     <= r_a >> 4;
            r_b     <= r_b >> 4;
            r_carry <= w_c[4];
            r_idx   <= r_idx + 1'b1;
            for (int i = 0; i < c_nibbles; i++) begin
                if (r_idx == c_idx_w'(i)) begin
                    r_d[4*i +: 4] <= w_sum;
                end
            end
            if (w_last) begin
                // Carry out of the top slice is the inverted borrow; overflow
                // is carry-into-MSB differing from carry-out-of-MSB.
                r_bout <= ~w_c[4];
                r_ovf  <= w_c[3] ^ w_c[4];
            end
        end
    end

    assign ready = w_ready;
    assign done  = w_done;
    assign d     = r_d;
    assign bout  = r_bout;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire
